fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter BUF_DEPTH, default 2, giving the instruction buffer entries (power of two, 2..8).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port fetch_en, input, 1 bit: high permits fetching; low halts fetching.
REQ-006 The block SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-007 The block SHALL have port redirect_pc, input, 32 bits: redirect target address.
REQ-008 The block SHALL have port imem_addr, output, 32 bits: byte address to the instruction memory.
REQ-009 The block SHALL have port imem_instr, input, 32 bits: instruction word, combinationally valid in the same cycle as imem_addr.
REQ-010 The block SHALL have port out_valid, output, 1 bit: buffer head holds an instruction.
REQ-011 The block SHALL have port out_ready, input, 1 bit: decode accepts the head.
REQ-012 The block SHALL have port out_instr, output, 32 bits: head instruction.
REQ-013 The block SHALL have port out_pc, output, 32 bits: head instruction address.

Function
REQ-014 States SHALL be IDLE, RUN, REDIRECT; imem_addr SHALL equal the registered fetch_pc in every state.
REQ-015 IDLE->RUN when fetch_en=1; RUN->IDLE when fetch_en=0; any state->REDIRECT when redirect_valid=1; REDIRECT->RUN (fetch_en=1) or IDLE (fetch_en=0) after exactly one cycle.
REQ-016 In RUN, when the buffer is not full, or is full and popped in the same cycle, {fetch_pc, imem_instr} SHALL be pushed and fetch_pc SHALL advance by 4.
REQ-017 fetch_pc SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-018 In IDLE and REDIRECT, no push SHALL occur and fetch_pc SHALL hold.
REQ-019 A pop SHALL occur when out_valid=1 and out_ready=1; out_valid SHALL be 1 exactly when the buffer count is nonzero.
REQ-020 out_instr and out_pc SHALL be driven from the buffer head register.
REQ-021 Fetch-to-out latency SHALL be one cycle: a word pushed at edge N is visible at the head after edge N when the buffer was empty.
REQ-022 redirect_valid SHALL have priority over push and pop: the buffer is emptied, fetch_pc loads {redirect_pc[31:2], 2'b00}, and a same-cycle handshake is discarded.
REQ-023 redirect_pc[1:0] SHALL be ignored.
REQ-024 With fetch_en=0, buffered entries SHALL remain poppable.
REQ-025 Buffer count SHALL never exceed BUF_DEPTH nor underflow; a pop on an empty buffer SHALL be impossible because out_valid=0.

Reset
REQ-026 While rst=1 at a clock edge: state=IDLE, fetch_pc=RESET_PC, buffer empty, out_valid=0, out_instr=0, out_pc=0.
REQ-027 Reset SHALL override redirect_valid, fetch_en and any handshake in the same cycle, including mid-redirect.

Configuration
REQ-028 With macro FETCH_PERF_EN defined, the block SHALL add output fetch_count, 32 bits, reset to 0, incremented on each pop, wrapping at 2^32, and not cleared by redirect.
REQ-029 Without FETCH_PERF_EN, port fetch_count and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Reset with RESET_PC=0x100, fetch_en=1, out_ready=1 -> imem_addr 0x100,0x104,0x108 on consecutive cycles; out_pc 0x100 one cycle after first fetch.
REQ-031 out_ready=0 with BUF_DEPTH=2 -> exactly 2 pushes, then fetch_pc holds at base+8; out_ready=1 -> push and pop in the same cycle, count stays 2.
REQ-032 redirect_valid=1 with redirect_pc=0x203 while buffer full -> out_valid=0 next cycle, imem_addr=0x200, first new out_pc=0x200 two cycles after the redirect.
REQ-033 fetch_pc=0xFFFF_FFFC in RUN -> next imem_addr=0x0000_0000.
REQ-034 rst asserted in the REDIRECT cycle -> state IDLE, imem_addr=RESET_PC, out_valid=0; with FETCH_PERF_EN, fetch_count=0 and equals the number of handshakes after 10 pops.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction fetch controller: PC sequencing, redirect handling and a small instruction buffer.
// Optional fetch_count performance counter is built when FETCH_PERF_EN is defined.
module fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  localparam int unsigned PW = $clog2(BUF_DEPTH);
  localparam logic [PW:0] DepthC = BUF_DEPTH[PW:0];

  typedef enum logic [1:0] {StIdle, StRun, StRedirect} state_e;

  state_e        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   buf_pc    [BUF_DEPTH];
  logic [31:0]   buf_instr [BUF_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          pop;
  logic          push;

  assign full      = (count == DepthC);
  assign out_valid = (count != '0);
  // A redirect discards any handshake seen in the same cycle.
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign push      = (state == StRun) && !redirect_valid && (!full || pop);
  assign imem_addr = fetch_pc;
  assign out_pc    = buf_pc[rd_ptr];
  assign out_instr = buf_instr[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      fetch_pc  <= RESET_PC;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      buf_pc    <= '{default: '0};
      buf_instr <= '{default: '0};
    end else if (redirect_valid) begin
      state    <= StRedirect;
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      case (state)
        StIdle, StRun, StRedirect: state <= fetch_en ? StRun : StIdle;
        default:                   state <= StIdle;
      endcase
      if (push) begin
        buf_pc[wr_ptr]    <= fetch_pc;
        buf_instr[wr_ptr] <= imem_instr;
        wr_ptr            <= wr_ptr + 1'b1;
        fetch_pc          <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
    end else if (pop) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios then random traffic, all compared
// against a queue-based reference model of the fetch/buffer behaviour.
module tb_fetch_controller;

  localparam logic [31:0] RstPc = 32'h0000_0100;
  localparam int Depth = 2;
  localparam int MIdle = 0, MRun = 1, MRedir = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
`endif

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  ent_t        q[$];
  logic [31:0] m_pc;
  int          m_mode;
  logic [31:0] m_perf;
  int          handshakes;

  fetch_controller #(
    .RESET_PC (RstPc),
    .BUF_DEPTH(Depth)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count   (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_fn(input logic [31:0] a);
    return {a[7:0] ^ 8'h5A, a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_instr = imem_fn(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("imem_addr", imem_addr, m_pc);
    check("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
    if (q.size() != 0) begin
      check("out_pc", out_pc, q[0].pc);
      check("out_instr", out_instr, q[0].instr);
    end
`ifdef FETCH_PERF_EN
    check("fetch_count", fetch_count, m_perf);
`endif
  endtask

  // Advance one clock: model update computed from current inputs, then compare.
  task automatic step();
    bit do_pop, do_push;
    logic [31:0] cur_pc;
    cur_pc  = m_pc;
    do_pop  = 1'b0;
    do_push = 1'b0;
    @(posedge clk);
    #1;
    if (rst) begin
      m_mode = MIdle;
      m_pc   = RstPc;
      q.delete();
      m_perf = '0;
    end else if (redirect_valid) begin
      q.delete();
      m_pc   = {redirect_pc[31:2], 2'b00};
      m_mode = MRedir;
    end else begin
      do_pop  = (q.size() > 0) && out_ready;
      do_push = (m_mode == MRun) && ((q.size() < Depth) || do_pop);
      if (do_pop) begin
        void'(q.pop_front());
        m_perf = m_perf + 32'd1;
        handshakes++;
      end
      if (do_push) begin
        q.push_back('{pc: cur_pc, instr: imem_fn(cur_pc)});
        m_pc = cur_pc + 32'd4;
      end
      m_mode = fetch_en ? MRun : MIdle;
    end
    check_all();
  endtask

  initial begin
    m_pc = '0; m_mode = MIdle; m_perf = '0; handshakes = 0;

    // Reset, then run with decode always ready
    rst = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
    step();
    check("rst_imem_addr", imem_addr, 32'h100);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    rst = 1'b0;
    step();
    check("run_addr0", imem_addr, 32'h100);
    step();
    check("run_addr1", imem_addr, 32'h104);
    check("first_out_pc", out_pc, 32'h100);
    step();
    check("run_addr2", imem_addr, 32'h108);

    // Backpressure fills the buffer, then simultaneous push/pop
    out_ready = 1'b0;
    repeat (4) step();
    check("full_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    repeat (3) step();
    check("stream_depth", q.size(), Depth);

    // Redirect while full, misaligned target
    out_ready = 1'b0;
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 32'h203; out_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("redir_valid", {31'b0, out_valid}, 32'd0);
    check("redir_addr", imem_addr, 32'h200);
    step();
    step();
    check("redir_out_pc", out_pc, 32'h200);

    // Address wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    check("wrap_addr", imem_addr, 32'h0000_0000);
    check("wrap_out_pc", out_pc, 32'hFFFF_FFFC);

    // Halted fetch leaves buffered entries poppable
    out_ready = 1'b0; step(); step();
    fetch_en = 1'b0; step();
    out_ready = 1'b1; repeat (3) step();
    check("halt_drained", {31'b0, out_valid}, 32'd0);

    // Reset during the redirect cycle
    fetch_en = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    step();
    redirect_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_redir_addr", imem_addr, 32'h100);
    check("rst_redir_valid", {31'b0, out_valid}, 32'd0);
    handshakes = 0;
    out_ready = 1'b1;
    repeat (12) step();
`ifdef FETCH_PERF_EN
    check("perf_count", fetch_count, handshakes);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst            = ($urandom_range(0, 49) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF))
                                                   : $urandom();
      fetch_en       = ($urandom_range(0, 3) != 0);
      out_ready      = $urandom_range(0, 1);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
